// File: rtl/decision_pkg.sv
// -----------------------------------------------------------------------------
// decision_pkg
// Shared definitions for the decision tree host-side sequencer and any other
// consumer of the tree's 8-bit result code:
//   - sequencer state encoding (IDLE/START/WAIT/HOLD)
//   - error codes reported alongside the decoded class
//   - the four legal result codes Y1..Y4 emitted by the tree
// -----------------------------------------------------------------------------
package decision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Error codes are carried on plain 2-bit buses; these are the legal values.
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BADCODE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_RSVD    = 2'd3;

  // Result codes produced by the tree, one per class.
  localparam logic [7:0] CODE_Y1 = 8'h01;
  localparam logic [7:0] CODE_Y2 = 8'h02;
  localparam logic [7:0] CODE_Y3 = 8'h03;
  localparam logic [7:0] CODE_Y4 = 8'h04;

  localparam int NUM_CLASSES = 4;

  // Wait timer width: covers the largest legal TIMEOUT_CYC of 255.
  localparam int TIMER_W = 8;

endpackage

// File: rtl/decision_decode.sv
// -----------------------------------------------------------------------------
// decision_decode
// Purely combinational decoder from the tree's 8-bit result code to a 2-bit
// class plus an error code. Unknown codes map to class 0 with BADCODE.
// Ports:
//   y_i      in  8  result code from the tree
//   class_o  out 2  decoded class (0 = Y1 .. 3 = Y4)
//   err_o    out 2  ERR_OK or ERR_BADCODE
// -----------------------------------------------------------------------------
module decision_decode
  import decision_pkg::*;
(
  input  logic [7:0] y_i,
  output logic [1:0] class_o,
  output logic [1:0] err_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps a combinational block free of latches.
    class_o = 2'd0;
    err_o   = ERR_OK;
    case (y_i)
      CODE_Y1: class_o = 2'd0;
      CODE_Y2: class_o = 2'd1;
      CODE_Y3: class_o = 2'd2;
      CODE_Y4: class_o = 2'd3;
      default: err_o   = ERR_BADCODE;
    endcase
  end

endmodule

// File: rtl/decision_sequencer.sv
// -----------------------------------------------------------------------------
// decision_sequencer
// Host-side controller for the decision tree classifier. Takes a host request,
// pulses start to the tree for one cycle, waits for the result strobe under a
// timeout, decodes the result and holds it until the host accepts it.
//
// Optional build macro DECISION_HIST_EN adds four saturating per-class hit
// counters with readback; without it cnt_o is tied to 0 and cnt_sel_i /
// clr_cnt_i are ignored.
//
// Parameters:
//   TIMEOUT_CYC  cycles spent in WAIT before a timeout (2..255)
//   CNT_W        width of each class counter
// Ports:
//   clk             in  1      rising-edge clock
//   reset_n         in  1      asynchronous active-low reset
//   req_i           in  1      host request, sampled in IDLE only
//   busy_o          out 1      high whenever not IDLE
//   start_o         out 1      one-cycle start pulse to the tree
//   y_i             in  8      tree result code
//   y_valid_i       in  1      tree result strobe, honoured in WAIT only
//   result_valid_o  out 1      result held for the host
//   result_ready_i  in  1      host accept
//   class_o         out 2      decoded class of the last capture
//   err_o           out 2      OK / BADCODE / TIMEOUT of the last capture
//   cnt_sel_i       in  2      class counter readback select
//   cnt_o           out CNT_W  selected counter value
//   clr_cnt_i       in  1      synchronous clear of all counters
// -----------------------------------------------------------------------------
module decision_sequencer
  import decision_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_i,
  output logic             busy_o,
  output logic             start_o,
  input  logic [7:0]       y_i,
  input  logic             y_valid_i,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic [1:0]       class_o,
  output logic [1:0]       err_o,
  input  logic [1:0]       cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o,
  input  logic             clr_cnt_i
);

  // Timer value seen in the last WAIT cycle before a timeout is declared.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [1:0]           class_q, class_d;
  logic [1:0]           err_q,   err_d;
  logic                 cnt_inc;

  logic [1:0]           dec_class;
  logic [1:0]           dec_err;

  decision_decode u_decode (
    .y_i     (y_i),
    .class_o (dec_class),
    .err_o   (dec_err)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic. class/err only change on a capture or a timeout, so they
  // persist through HOLD and back into IDLE until the next transaction.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    class_d = class_q;
    err_d   = err_q;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) state_d = ST_START;
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A strobe in the final timer cycle still counts as a valid result.
        if (y_valid_i) begin
          class_d = dec_class;
          err_d   = dec_err;
          cnt_inc = (dec_err == ERR_OK);
          state_d = ST_HOLD;
        end else if (timer_q == TIMER_LAST) begin
          class_d = 2'd0;
          err_d   = ERR_TIMEOUT;
          state_d = ST_HOLD;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_HOLD: begin
        if (result_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      class_q <= 2'd0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from registered state, so they are glitch-free
  // and start_o is exactly one cycle wide.
  assign busy_o         = (state_q != ST_IDLE);
  assign start_o        = (state_q == ST_START);
  assign result_valid_o = (state_q == ST_HOLD);
  assign class_o        = class_q;
  assign err_o          = err_q;

  // ---------------------------------------------------------------------------
  // Per-class hit counters
  // ---------------------------------------------------------------------------
`ifdef DECISION_HIST_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];

  // Clear beats a same-cycle increment; counters stick at CNT_MAX.
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt_i) begin
        cnt_d[i] = '0;
      end else if (cnt_inc && (class_d == 2'(i)) && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: this small register array is reset on purpose: the counters are
    // architecturally visible and must read 0 after reset. Large storage
    // arrays that are written before being read are normally left unreset.
    if (!reset_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_o = cnt_q[cnt_sel_i];
`else
  assign cnt_o = '0;

  logic unused_hist;
  assign unused_hist = ^{cnt_sel_i, clr_cnt_i, cnt_inc};
`endif

endmodule

// File: tb/tb_decision_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decision_sequencer
// Self-checking bench for decision_sequencer (TIMEOUT_CYC = 16, CNT_W = 2).
// A table of transactions drives requests and tree responses; expected
// {class, err} results are queued when each request is issued and popped by a
// monitor on every host transfer. Counter expectations come from a small
// saturating model and are zero when DECISION_HIST_EN is not defined.
// -----------------------------------------------------------------------------
module tb_decision_sequencer;

  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

`ifdef DECISION_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif

  localparam logic [1:0] OK  = 2'd0;
  localparam logic [1:0] BAD = 2'd1;
  localparam logic [1:0] TMO = 2'd2;

  logic             clk;
  logic             reset_n;
  logic             req_i;
  logic             busy_o;
  logic             start_o;
  logic [7:0]       y_i;
  logic             y_valid_i;
  logic             result_valid_o;
  logic             result_ready_i;
  logic [1:0]       class_o;
  logic [1:0]       err_o;
  logic [1:0]       cnt_sel_i;
  logic [CNT_W-1:0] cnt_o;
  logic             clr_cnt_i;

  decision_sequencer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_i          (req_i),
    .busy_o         (busy_o),
    .start_o        (start_o),
    .y_i            (y_i),
    .y_valid_i      (y_valid_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .class_o        (class_o),
    .err_o          (err_o),
    .cnt_sel_i      (cnt_sel_i),
    .cnt_o          (cnt_o),
    .clr_cnt_i      (clr_cnt_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0] cls;
    logic [1:0] err;
  } exp_t;

  // dly: WAIT cycle index at which y_valid_i is driven (-1 = never -> timeout)
  typedef struct {
    logic [7:0] code;
    int         dly;
    int         stall;
    bit         b2b;
    bit         clr;
    logic [1:0] cls;
    logic [1:0] err;
    int         lat;
  } vec_t;

  int   checks    = 0;
  int   passes    = 0;
  int   start_cnt = 0;
  int   model_cnt [4];
  exp_t sb_q [$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: samples just after the falling edge, when the bench has finished
  // driving. A transfer is valid && ready ahead of the next rising edge.
  always @(negedge clk) begin
    #1;
    if (reset_n && result_valid_o && result_ready_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected: transfer class=%0d err=%0d with nothing expected",
                 class_o, err_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_class", 32'(class_o), 32'(mon_e.cls));
        check("sb_err",   32'(err_o),   32'(mon_e.err));
      end
    end
    if (start_o) start_cnt++;
  end

  // Hard stop in case a bounded wait is itself broken.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic issue_req();
    req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic check_cnts(input string tag);
    for (int i = 0; i < 4; i++) begin
      cnt_sel_i = 2'(i);
      #1;
      check($sformatf("%s_cnt%0d", tag, i), 32'(cnt_o), HIST ? 32'(model_cnt[i]) : 32'd0);
    end
    cnt_sel_i = 2'd0;
  endtask

  // Entered at the falling edge inside the START cycle.
  task automatic txn(input vec_t v);
    int         lat;
    int         j;
    bit         seen;
    int         s0;
    logic [1:0] c0;
    logic [1:0] e0;
    exp_t       ex;

    ex.cls = v.cls;
    ex.err = v.err;
    sb_q.push_back(ex);

    check("start_pulse", 32'(start_o), 32'd1);
    check("busy_start",  32'(busy_o),  32'd1);

    lat  = 1;
    j    = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        check("start_width", 32'(start_o), 32'd0);
        check("busy_wait",   32'(busy_o),  32'd1);
      end
      if (result_valid_o) begin
        seen = 1'b1;
      end else begin
        y_valid_i = (v.dly >= 0) && (j == v.dly);
        y_i       = v.code;
        clr_cnt_i = y_valid_i && v.clr;
        j++;
      end
    end
    y_valid_i = 1'b0;
    clr_cnt_i = 1'b0;
    check("result_seen", 32'(seen), 32'd1);
    check("latency",     32'(lat),  32'(v.lat));

    if (v.clr) begin
      for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    end else if (v.err == OK && model_cnt[v.cls] < CNT_MAX) begin
      model_cnt[v.cls]++;
    end

    // Stall: outputs must hold; a new request and a stray strobe are ignored.
    s0 = start_cnt;
    c0 = class_o;
    e0 = err_o;
    for (int k = 0; k < v.stall; k++) begin
      req_i     = 1'b1;
      y_valid_i = 1'b1;
      y_i       = 8'h02;
      @(negedge clk);
      check("stall_valid", 32'(result_valid_o), 32'd1);
      check("stall_class", 32'(class_o), 32'(c0));
      check("stall_err",   32'(err_o),   32'(e0));
    end
    y_valid_i      = 1'b0;
    req_i          = v.b2b;
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
    check("valid_drop",   32'(result_valid_o), 32'd0);
    check("busy_idle",    32'(busy_o),  32'd0);
    check("class_held",   32'(class_o), 32'(c0));
    check("err_held",     32'(err_o),   32'(e0));
    check("single_start", 32'(start_cnt), 32'(s0));
    if (v.b2b) begin
      @(negedge clk);
      req_i = 1'b0;
    end else begin
      req_i = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  vec_t tbl [10];
  vec_t v;
  bit   pre;

  initial begin
    //             code   dly stall b2b clr cls   err  lat
    tbl[0] = '{8'h01,   0,  0,   0,  0, 2'd0, OK,   3};
    tbl[1] = '{8'h02,   1,  0,   0,  0, 2'd1, OK,   4};
    tbl[2] = '{8'h03,   1,  0,   1,  0, 2'd2, OK,   4};
    tbl[3] = '{8'h04,   2,  0,   0,  0, 2'd3, OK,   5};
    tbl[4] = '{8'h07,   0,  0,   0,  0, 2'd0, BAD,  3};
    tbl[5] = '{8'h00,   3,  0,   0,  0, 2'd0, BAD,  6};
    tbl[6] = '{8'hFF,   0, 10,   0,  0, 2'd0, BAD,  3};
    tbl[7] = '{8'h03,  15,  0,   0,  0, 2'd2, OK,  18};
    tbl[8] = '{8'h03,  -1,  0,   0,  0, 2'd0, TMO, 18};
    tbl[9] = '{8'h02,  14,  3,   0,  0, 2'd1, OK,  17};
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;

    reset_n        = 1'b0;
    req_i          = 1'b1;
    y_i            = 8'h00;
    y_valid_i      = 1'b0;
    result_ready_i = 1'b0;
    cnt_sel_i      = 2'd0;
    clr_cnt_i      = 1'b0;

    // Reset held with a pending request: everything stays quiet.
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_o),         32'd0);
    check("rst_start", 32'(start_o),        32'd0);
    check("rst_valid", 32'(result_valid_o), 32'd0);
    check("rst_class", 32'(class_o),        32'd0);
    check("rst_err",   32'(err_o),          32'd0);
    check_cnts("rst");

    // Release: the pending request starts on the first edge.
    reset_n = 1'b1;
    @(negedge clk);
    check("start_after_reset", 32'(start_o), 32'd1);
    req_i = 1'b0;
    @(negedge clk);
    check("start_one_cycle", 32'(start_o), 32'd0);
    check("busy_in_wait",    32'(busy_o),  32'd1);

    // Reset mid-WAIT drops straight back to IDLE.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy",  32'(busy_o),         32'd0);
    check("midrst_valid", 32'(result_valid_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst",  32'(busy_o),  32'd0);
    check("nostart_after_rst", 32'(start_o), 32'd0);

    // Strobe while IDLE is ignored.
    y_valid_i = 1'b1;
    y_i       = 8'h04;
    @(negedge clk);
    y_valid_i = 1'b0;
    check("idle_strobe_busy",  32'(busy_o),  32'd0);
    check("idle_strobe_class", 32'(class_o), 32'd0);
    check("idle_strobe_err",   32'(err_o),   32'd0);
    @(negedge clk);

    // Table-driven transactions.
    pre = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!pre) issue_req();
      txn(tbl[i]);
      pre = tbl[i].b2b;
    end
    check_cnts("table");

    // Saturation: five Y4 results.
    v = '{8'h04, 0, 0, 0, 0, 2'd3, OK, 3};
    for (int i = 0; i < 5; i++) begin
      issue_req();
      txn(v);
    end
    check_cnts("sat");

    // Clear coincident with a Y1 capture wins.
    v = '{8'h01, 0, 0, 0, 1, 2'd0, OK, 3};
    issue_req();
    txn(v);
    check_cnts("clr");

    // Counting resumes after the clear.
    v = '{8'h02, 1, 0, 0, 0, 2'd1, OK, 4};
    issue_req();
    txn(v);
    check_cnts("post_clr");

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/decision_sequencer.md
# decision_sequencer

Host-side controller for the decision tree classifier. It accepts a host request, issues a one-cycle start pulse to the tree, and waits for the tree's result strobe under a timeout. It then decodes the 8-bit result code into a 2-bit class plus an error code and holds the result until the host accepts it. Optional per-class hit counters can be read back. The block sits between the host/register interface and the decision tree core, on the opposite end of the tree's start/result interface.

## Interface
- `TIMEOUT_CYC`, 16: cycles in WAIT before a timeout is declared; legal range 2..255.
- `CNT_W`, 8: width of each saturating class counter.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_i` in 1: host request, level-sampled in IDLE.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `start_o` out 1: start pulse to the tree, exactly one cycle wide.
- `y_i` in 8: result code from the tree.
- `y_valid_i` in 1: result strobe from the tree.
- `result_valid_o` out 1: result held for the host.
- `result_ready_i` in 1: host accept.
- `class_o` out 2: decoded class; 0 = Y1, 1 = Y2, 2 = Y3, 3 = Y4.
- `err_o` out 2: 0 = OK, 1 = BADCODE, 2 = TIMEOUT, 3 = reserved.
- `cnt_sel_i` in 2: selects which class counter is read back.
- `cnt_o` out CNT_W: selected counter value, combinational from the counter registers.
- `clr_cnt_i` in 1: synchronous clear of all counters.

## Operation
- States and transitions:
  - IDLE: leave for START when `req_i` is 1.
  - START: `start_o` is 1; go to WAIT unconditionally.
  - WAIT: timer counts from 0. If `y_valid_i` is 1, capture and go to HOLD. Otherwise, when timer = TIMEOUT_CYC−1, set TIMEOUT and go to HOLD.
  - HOLD: `result_valid_o` is 1. When `result_ready_i` is 1, go to IDLE.
- Decode on capture:
  - y = 8'h01 → class 0; 8'h02 → class 1; 8'h03 → class 2; 8'h04 → class 3; `err_o` = OK.
  - Any other code → `class_o` = 0, `err_o` = BADCODE.
- On timeout: `class_o` = 0, `err_o` = TIMEOUT.
- `y_valid_i` outside WAIT is ignored and changes nothing.
- `req_i` while busy is ignored; requests are not queued.
- `y_valid_i` in the timeout cycle: the valid result wins and no TIMEOUT is flagged.
- `class_o`/`err_o` hold their last captured values until the next capture, including after IDLE is re-entered.
- Reset asserted mid-operation: return to IDLE immediately. No start pulse or result is emitted, and counters clear.

## Timing
- Reset values: `busy_o`, `start_o`, `result_valid_o` = 0; `class_o` = 0; `err_o` = 0; all counters = 0; state = IDLE.
- `req_i` high at edge n → `start_o` high in cycle n+1 only.
- `y_valid_i` sampled in WAIT at edge m → `result_valid_o` high from cycle m+1.
- Minimum request-to-result latency is 3 cycles.
- Timeout: `result_valid_o` rises TIMEOUT_CYC+2 cycles after the `req_i` edge.
- Handshake:
  - Transfer occurs when `result_valid_o` and `result_ready_i` are both 1 at an edge.
  - `result_valid_o` drops the next cycle.
  - `result_valid_o`, `class_o` and `err_o` are stable while stalled.
- Back-to-back requests: `req_i` held high during the transfer edge → IDLE for one cycle, then START.
- Counters: increment on the capture edge for class c when err = OK. They saturate at 2^CNT_W−1 and do not wrap.
- `clr_cnt_i` takes priority over an increment in the same cycle; the cleared counter reads 0.

## Configuration
- `DECISION_HIST_EN` defined: the four class counters, `cnt_sel_i` readback and `clr_cnt_i` are implemented as above.
- `DECISION_HIST_EN` undefined: no counter registers exist, `cnt_o` is tied to 0, and `cnt_sel_i`/`clr_cnt_i` are ignored. The sequencer itself is unchanged.

## Structure
- Shared package `decision_pkg` holds:
  - state encoding (IDLE/START/WAIT/HOLD);
  - err codes OK/BADCODE/TIMEOUT;
  - result codes Y1..Y4 = 8'h01..8'h04.
- One sub-module, `decision_decode`: combinational `y_i` → {class, err}, reused by any other consumer of the tree output.

## Test plan
- Reset with `req_i` = 1, then release `reset_n` → `start_o` pulses 1 cycle later; all outputs 0 while in reset.
- `req_i`; tree returns 8'h03 two cycles after the start pulse; `result_ready_i` = 1 → `class_o` = 2, `err_o` = 0, counter[2] = 1, one-cycle `result_valid_o`.
- `y_i` = 8'h07 with valid → `class_o` = 0, `err_o` = 1, no counter change.
- No `y_valid_i`, `TIMEOUT_CYC` = 16 → `err_o` = 2 and `result_valid_o` rises 18 cycles after the `req_i` edge. Repeat with valid landing in the 16th WAIT cycle → `err_o` = 0.
- Hold `result_ready_i` = 0 for 10 cycles → outputs stable, a second `req_i` is ignored, exactly one start pulse.
- `DECISION_HIST_EN` with `CNT_W` = 2:
  - five Y4 results → counter[3] saturates at 3;
  - `clr_cnt_i` coincident with a Y1 capture → counter[0] = 0.
